// File: rtl/lock_reg_arbiter.sv
// Lockable protected register with a two-requester round-robin write arbiter
// and a key-gated debug session that scrubs the register on entry.
module lock_reg_arbiter #(
  parameter logic [15:0] DBG_KEY     = 16'hA5C3,
  parameter int unsigned DBG_TIMEOUT = 8
) (
  input  logic        Clk,
  input  logic        resetn,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic        Lock,
  input  logic        dbg_req,
  input  logic [15:0] dbg_key,
  output logic        gnt0,
  output logic        gnt1,
  output logic        err,
  output logic [15:0] Data_out,
  output logic        lock_status,
  output logic        dbg_active
);

  localparam int unsigned DW = 16;
  localparam int unsigned TW = 8;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(DBG_TIMEOUT);

  typedef enum logic [1:0] {
    OPEN     = 2'd0,
    LOCKED   = 2'd1,
    DBG_WAIT = 2'd2,
    DEBUG    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            last_q, last_d;
  logic            gnt0_q, gnt0_d;
  logic            gnt1_q, gnt1_d;
  logic            err_q, err_d;
  logic [DW-1:0]   data_q, data_d;
  logic            lock_status_q, lock_status_d;
  logic            dbg_active_q, dbg_active_d;

  logic            elig0, elig1, sel1, serve, scrub, key_err, write_rej;

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= OPEN;
      timer_q       <= '0;
      last_q        <= 1'b1;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      err_q         <= 1'b0;
      data_q        <= '0;
      lock_status_q <= 1'b0;
      dbg_active_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      last_q        <= last_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      err_q         <= err_d;
      data_q        <= data_d;
      lock_status_q <= lock_status_d;
      dbg_active_q  <= dbg_active_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    last_d    = last_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    data_d    = data_q;
    scrub     = 1'b0;
    key_err   = 1'b0;
    write_rej = 1'b0;

    // A requester whose grant is showing sits out one cycle so it can drop req.
    elig0 = req0 & ~gnt0_q;
    elig1 = req1 & ~gnt1_q;
    sel1  = elig1 & (~elig0 | ~last_q);
    serve = elig0 | elig1;

    unique case (state_q)
      OPEN: begin
        if (Lock) state_d = LOCKED;
      end
      LOCKED: begin
        if (dbg_req) begin
          state_d = DBG_WAIT;
          timer_d = TIMER_LOAD;
        end
      end
      DBG_WAIT: begin
        if (timer_q != '0) timer_d = timer_q - TW'(1);
        // The first wait cycle (timer still at its load value) never rejects.
        if (dbg_key == DBG_KEY) begin
          state_d = DEBUG;
          scrub   = 1'b1;
          data_d  = '0;
        end else if (dbg_req && (timer_q < TIMER_LOAD)) begin
          state_d = LOCKED;
          key_err = 1'b1;
        end else if (!dbg_req) begin
          state_d = LOCKED;
        end else if (timer_q == '0) begin
          state_d = LOCKED;
          key_err = 1'b1;
        end
      end
      DEBUG: begin
        if (!dbg_req) state_d = LOCKED;
      end
      default: state_d = OPEN;
    endcase

    if (serve && !scrub) begin
      last_d = sel1;
      gnt0_d = ~sel1;
      gnt1_d = sel1;
      if (((state_q == OPEN) && !Lock) || (state_q == DEBUG)) begin
        data_d = sel1 ? data1 : data0;
      end else begin
        write_rej = 1'b1;
      end
    end

    err_d         = key_err | write_rej;
    lock_status_d = (state_d != OPEN);
    dbg_active_d  = (state_d == DEBUG);
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign err         = err_q;
  assign Data_out    = data_q;
  assign lock_status = lock_status_q;
  assign dbg_active  = dbg_active_q;

endmodule

// File: tb/tb_lock_reg_arbiter.sv
// Directed bench for lock_reg_arbiter: a transaction-level model is compared
// against the DUT every cycle, plus hand-computed spot checks.
module tb_lock_reg_arbiter;

  localparam logic [15:0] KEY = 16'hA5C3;
  localparam int          TMO = 8;

  logic        Clk, resetn;
  logic        req0, req1, Lock, dbg_req;
  logic [15:0] data0, data1, dbg_key;
  logic        gnt0, gnt1, err, lock_status, dbg_active;
  logic [15:0] Data_out;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  lock_reg_arbiter #(.DBG_KEY(KEY), .DBG_TIMEOUT(TMO)) dut (
    .Clk(Clk), .resetn(resetn), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .Lock(Lock), .dbg_req(dbg_req),
    .dbg_key(dbg_key), .gnt0(gnt0), .gnt1(gnt1), .err(err),
    .Data_out(Data_out), .lock_status(lock_status), .dbg_active(dbg_active)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=open 1=locked 2=waiting for key 3=debug; m_wait counts
  // cycles already spent waiting for the key.
  int          m_mode, m_last, m_wait;
  bit          m_gnt0, m_gnt1, m_err;
  logic [15:0] m_data;

  always @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      m_mode <= 0; m_last <= 1; m_wait <= 0;
      m_gnt0 <= 0; m_gnt1 <= 0; m_err <= 0; m_data <= 16'h0000;
    end else begin
      automatic int          nmode = m_mode;
      automatic int          who   = -1;
      automatic int          nwait = m_wait + 1;
      automatic bit          kerr  = 0;
      automatic bit          rej   = 0;
      automatic bit          scrub = 0;
      automatic logic [15:0] nd    = m_data;
      automatic bit          can0  = req0 && !m_gnt0;
      automatic bit          can1  = req1 && !m_gnt1;
      if (can0 && can1) who = 1 - m_last;
      else if (can0)    who = 0;
      else if (can1)    who = 1;
      if (m_mode == 0) begin
        if (Lock) nmode = 1;
      end else if (m_mode == 1) begin
        if (dbg_req) begin nmode = 2; nwait = 0; end
      end else if (m_mode == 2) begin
        if (dbg_key == KEY) begin nmode = 3; scrub = 1; nd = 16'h0000; end
        else if (!dbg_req) nmode = 1;
        else if (m_wait >= 1 || m_wait >= TMO) begin nmode = 1; kerr = 1; end
      end else begin
        if (!dbg_req) nmode = 1;
      end
      if (who >= 0 && !scrub) begin
        if ((m_mode == 0 && !Lock) || m_mode == 3) nd = (who == 1) ? data1 : data0;
        else rej = 1;
        m_last <= who;
      end
      m_gnt0 <= (who == 0) && !scrub;
      m_gnt1 <= (who == 1) && !scrub;
      m_err  <= kerr || rej;
      m_mode <= nmode;
      m_wait <= nwait;
      m_data <= nd;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("gnt0", 16'(gnt0), 16'(m_gnt0));
      chk("gnt1", 16'(gnt1), 16'(m_gnt1));
      chk("err", 16'(err), 16'(m_err));
      chk("Data_out", Data_out, m_data);
      chk("lock_status", 16'(lock_status), 16'(m_mode != 0));
      chk("dbg_active", 16'(dbg_active), 16'(m_mode == 3));
      chk("one_grant", 16'(gnt0 & gnt1), 16'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  initial begin
    int nerr;
    bit saw_dbg;
    resetn = 0; req0 = 0; req1 = 0; Lock = 0; dbg_req = 0;
    data0 = 16'h0; data1 = 16'h0; dbg_key = 16'h0;
    tick();
    chk("rst_gnt0", 16'(gnt0), 16'h0);
    chk("rst_gnt1", 16'(gnt1), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_data", Data_out, 16'h0000);
    chk("rst_lock", 16'(lock_status), 16'h0);
    chk("rst_dbg", 16'(dbg_active), 16'h0);
    chk_en = 1; resetn = 1;
    tick();

    // Single write in OPEN
    req0 = 1; data0 = 16'h1234; tick(); req0 = 0;
    chk("open_gnt0", 16'(gnt0), 16'h1);
    chk("open_data", Data_out, 16'h1234);
    chk("open_err", 16'(err), 16'h0);
    req1 = 1; data1 = 16'h5678; tick(); req1 = 0;
    chk("open_gnt1", 16'(gnt1), 16'h1);
    chk("open_data1", Data_out, 16'h5678);
    tick();

    // Contention: alternation 0,1,0,1
    req0 = 1; req1 = 1; data0 = 16'h1111; data1 = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_gnt0", 16'(gnt0), 16'((i % 2) == 0));
      chk("rr_gnt1", 16'(gnt1), 16'((i % 2) == 1));
    end
    req0 = 0; req1 = 0;
    chk("rr_data", Data_out, 16'h2222);
    tick();

    // Lock, then a rejected write
    Lock = 1; tick(); Lock = 0;
    chk("lock_status", 16'(lock_status), 16'h1);
    req1 = 1; data1 = 16'hBEEF; tick(); req1 = 0;
    chk("locked_gnt1", 16'(gnt1), 16'h1);
    chk("locked_err", 16'(err), 16'h1);
    chk("locked_data", Data_out, 16'h2222);

    // Wrong key held for 8 cycles
    dbg_req = 1; dbg_key = 16'h0000; nerr = 0; saw_dbg = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (err) nerr++;
      if (dbg_active) saw_dbg = 1;
    end
    chk("badkey_err_count", 16'(nerr), 16'd2);
    chk("badkey_no_debug", 16'(saw_dbg), 16'h0);
    dbg_req = 0; tick();

    // Correct key: scrub, pending write held over the scrub cycle
    dbg_req = 1; dbg_key = KEY; tick();
    chk("wait_not_debug", 16'(dbg_active), 16'h0);
    req0 = 1; data0 = 16'h00FF; tick();
    chk("scrub_dbg", 16'(dbg_active), 16'h1);
    chk("scrub_data", Data_out, 16'h0000);
    chk("scrub_no_gnt", 16'(gnt0), 16'h0);
    tick(); req0 = 0;
    chk("debug_gnt0", 16'(gnt0), 16'h1);
    chk("debug_data", Data_out, 16'h00FF);
    chk("debug_err", 16'(err), 16'h0);
    tick();

    // Asynchronous reset mid-DEBUG
    #2 resetn = 0;
    #1;
    chk("arst_data", Data_out, 16'h0000);
    chk("arst_dbg", 16'(dbg_active), 16'h0);
    chk("arst_lock", 16'(lock_status), 16'h0);
    chk("arst_gnt", 16'({gnt0, gnt1, err}), 16'h0);
    tick();
    resetn = 1; dbg_req = 0; dbg_key = 16'h0;
    req0 = 1; data0 = 16'hCAFE; tick(); req0 = 0;
    chk("post_rst_gnt0", 16'(gnt0), 16'h1);
    chk("post_rst_data", Data_out, 16'hCAFE);
    chk("post_rst_open", 16'(lock_status), 16'h0);
    tick();

    // Lock and write in the same cycle: lock wins
    Lock = 1; req1 = 1; data1 = 16'hDEAD; tick(); Lock = 0; req1 = 0;
    chk("lockwin_gnt1", 16'(gnt1), 16'h1);
    chk("lockwin_err", 16'(err), 16'h1);
    chk("lockwin_data", Data_out, 16'hCAFE);
    chk("lockwin_status", 16'(lock_status), 16'h1);

    // Write during key wait is rejected; then mixed traffic during key errors
    dbg_req = 1; dbg_key = 16'h1357; tick();
    req0 = 1; data0 = 16'h7777; tick();
    chk("wait_rej_gnt0", 16'(gnt0), 16'h1);
    chk("wait_rej_err", 16'(err), 16'h1);
    chk("wait_rej_data", Data_out, 16'hCAFE);
    req1 = 1; data1 = 16'h8888;
    repeat (6) tick();
    req0 = 0; req1 = 0; dbg_req = 0;
    repeat (3) tick();

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
